sccb_reg_responder: RTL and testbench
=====================================

# sccb_reg_responder

SCCB/I2C slave that answers the camera-configuration master exactly as an OV7725 would at the register level. Holds a 256 x 8 register file with fixed read-only ID registers, and accepts 3-phase writes and 2-phase reads. Reports every accepted write on a side-band strobe. Sits opposite the SCCB configuration master: in the bench as a sensor model, and on-board as a loop-back target for bring-up of the OV7725 config path.

## Interface
Parameters:
- DEV_ADDR, 7'h21: 7-bit device address. Write byte 0x42, read byte 0x43.
- SOFT_RST_ADDR, 8'h12: register whose bit[7] triggers a soft reset (COM7).

Ports:
- clk  in  1  system clock; must be at least 16 x SCL.
- rst_n  in  1  asynchronous, active-low reset.
- scl  in  1  SCCB clock from master (asynchronous).
- sda_in  in  1  SDA line level (asynchronous).
- sda_oe  out  1  1 = pull SDA low. Pad is open-drain, so 0 releases the line.
- wr_valid  out  1  one-cycle strobe per accepted data write.
- wr_addr  out  8  sub-address of the accepted write; valid with wr_valid.
- wr_data  out  8  data of the accepted write; valid with wr_valid.
- busy  out  1  high during soft-reset clear sweep.
- soft_rst  out  1  one-cycle pulse when a soft reset is accepted.

## Operation
- Line conditioning:
  - scl and sda_in each pass through a 2-flop synchronizer plus a history flop.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Bits are sampled on the detected SCL rise. sda_oe changes only on the cycle after a detected SCL fall.
- States:
  - IDLE → DEV (on START) → DEV_ACK → SUB → SUB_ACK → WDATA → WDATA_ACK (loops back to WDATA).
  - DEV_ACK → RDATA → RACK (loops to RDATA).
  - CLEAR (soft reset sweep).
- START in any state except CLEAR → DEV with the bit counter at 0. This covers repeated start.
- STOP in any state except CLEAR → IDLE and releases sda_oe.
- DEV: shift 8 bits MSB first.
  - Address mismatch, or busy: return to IDLE, sda_oe stays 0 (NACK).
  - Match with R/W=0: ACK, then go to SUB.
  - Match with R/W=1: ACK, then go to RDATA.
- SUB: 8 bits load the pointer, then ACK.
- WDATA: 8 bits, then ACK. At the ACK cycle:
  - Write the register file at the pointer.
  - Pulse wr_valid with wr_addr = pointer, wr_data = byte.
  - Increment the pointer; 0xFF wraps to 0x00.
- Read-only addresses 0x0A, 0x0B, 0x1C, 0x1D:
  - Writes are ACKed and the pointer increments.
  - The array is not updated and wr_valid is not pulsed.
  - Reads return 0x77, 0x21, 0x7F, 0xA2 respectively; this is hard mux logic, not RAM content.
- RDATA: drive the register at the pointer MSB first (sda_oe = ~bit), then release for the master's ACK bit.
  - On that bit's SCL rise, the pointer increments.
  - Master ACK (SDA=0) → RDATA with the next byte. Master NACK → IDLE.
- Soft reset: a write to SOFT_RST_ADDR with data bit[7]=1:
  - Pulses soft_rst and wr_valid as usual.
  - After the following STOP, enters CLEAR.
- CLEAR:
  - Writes 0x00 to addresses 0x00..0xFF, one per clk (256 cycles), with busy=1.
  - Then IDLE, pointer = 0x00.
  - Line events are ignored, and DEV matches are NACKed while busy.
- rst_n low, including mid-transaction:
  - All outputs 0, state IDLE, pointer 0x00, synchronizers set to 1 (idle bus).
  - Register array content is undefined until the first soft reset. The bench clears it via 0x12=0x80.

## Timing
- Reset values: sda_oe=0, wr_valid=0, wr_addr=0x00, wr_data=0x00, busy=0, soft_rst=0.
- Input-to-detect latency: 3 clk after a pad edge.
- Drive latency: sda_oe is updated 4 clk after the pad SCL fall. This is well inside the low phase at ≥16x oversampling.
- ACK: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after the 9th bit.
- wr_valid: 1 cycle, asserted on the detected SCL rise of the 9th (ACK) bit.
- Read data: the first read bit is driven after the SCL fall that ends DEV_ACK.
- CLEAR: exactly 256 cycles from the cycle after the STOP detect. busy deasserts on cycle 257.
- START and STOP detected in the same cycle as an SCL edge: the line condition takes priority; the bit is discarded.

## Structure
- Package sccb_pkg:
  - state enum.
  - ID constants: 0x0A/0x77, 0x0B/0x21, 0x1C/0x7F, 0x1D/0xA2.
  - Default DEV_ADDR.
  - Shared with the SCCB master and its testbench.
- Sub-module sccb_line_sync: synchronizers plus scl_rise, scl_fall, start, stop strobes.
- Register array: inferred 256x8 single-port RAM in the top level.

## Test plan
- Write 0x42, 0x3D, 0x03, STOP → ACK on all three bytes; wr_valid once with addr 0x3D, data 0x03. Then read 0x42, 0x3D, STOP, START, 0x43 → returns 0x03.
- Read 0x1C with a master ACK then NACK → bytes 0x7F, 0xA2. Write 0xFF to 0x1C → no wr_valid; a re-read still returns 0x7F.
- Address 0x60 → sda_oe stays 0 through the 9th bit; state IDLE; no wr_valid.
- Write 0x12=0x80, STOP → soft_rst pulse; busy high exactly 256 clk. Address 0x42 during busy → NACK. Afterwards reading 0x3D returns 0x00.
- Burst write at pointer 0xFE with 3 data bytes → wr_addr 0xFE, 0xFF, 0x00.
- rst_n low while sda_oe=1 mid-read → sda_oe=0 immediately; next START/0x42 is ACKed normally.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder states, OV7725 ID registers, default addresses.
package sccb_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_COUNT = 256;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [6:0] SCCB_DEV_ADDR      = 7'h21;
  localparam logic [7:0] SCCB_SOFT_RST_ADDR = 8'h12;

  localparam logic [7:0] ID_PID_ADDR  = 8'h0A;
  localparam logic [7:0] ID_PID_VAL   = 8'h77;
  localparam logic [7:0] ID_VER_ADDR  = 8'h0B;
  localparam logic [7:0] ID_VER_VAL   = 8'h21;
  localparam logic [7:0] ID_MIDH_ADDR = 8'h1C;
  localparam logic [7:0] ID_MIDH_VAL  = 8'h7F;
  localparam logic [7:0] ID_MIDL_ADDR = 8'h1D;
  localparam logic [7:0] ID_MIDL_VAL  = 8'hA2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_CLEAR
  } sccb_state_t;

  function automatic logic is_id_reg(input logic [7:0] addr);
    return (addr == ID_PID_ADDR) || (addr == ID_VER_ADDR) ||
           (addr == ID_MIDH_ADDR) || (addr == ID_MIDL_ADDR);
  endfunction

  function automatic logic [7:0] id_reg_val(input logic [7:0] addr);
    logic [7:0] val;
    case (addr)
      ID_PID_ADDR:  val = ID_PID_VAL;
      ID_VER_ADDR:  val = ID_VER_VAL;
      ID_MIDH_ADDR: val = ID_MIDH_VAL;
      ID_MIDL_ADDR: val = ID_MIDL_VAL;
      default:      val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA and produces registered edge and START/STOP strobes.
module sccb_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;

  // Reset to the idle-bus level so release from reset never looks like an edge on SDA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
      sda      <= sda_sync[1];
      scl_rise <= scl_sync[1] & ~scl_hist;
      scl_fall <= ~scl_sync[1] & scl_hist;
      start    <= scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
      stop     <= scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];
    end
  end

endmodule

// File: rtl/sccb_reg_responder.sv
// OV7725-style SCCB register responder: 256x8 register file, fixed ID registers,
// write side-band strobe and COM7 soft-reset clear sweep.
module sccb_reg_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = SCCB_DEV_ADDR,
  parameter logic [7:0] SOFT_RST_ADDR = SCCB_SOFT_RST_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              soft_rst
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);
  localparam logic [DATA_W-1:0]    LAST_REG  = DATA_W'(REG_COUNT - 1);

  logic sda_s, scl_rise, scl_fall, start, stop;

  sccb_line_sync u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  sccb_state_t          state, state_d;
  logic [BIT_CNT_W-1:0] cnt, cnt_d;
  logic [DATA_W-1:0]    shreg, shreg_d, tx, tx_d, ptr, ptr_d, clr_cnt, clr_cnt_d;
  logic                 rnw, rnw_d, clr_pend, clr_pend_d;
  logic                 sda_oe_d, wr_valid_d, busy_d, soft_rst_d;
  logic [DATA_W-1:0]    wr_addr_d, wr_data_d;

  logic                 mem_we;
  logic [DATA_W-1:0]    mem_waddr, mem_wdata, rd_byte;
  logic [DATA_W-1:0]    mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ID registers are hard-wired and shadow the array.
  assign rd_byte = is_id_reg(ptr) ? id_reg_val(ptr) : mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      clr_cnt  <= '0;
      rnw      <= 1'b0;
      clr_pend <= 1'b0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      soft_rst <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
      ptr      <= ptr_d;
      clr_cnt  <= clr_cnt_d;
      rnw      <= rnw_d;
      clr_pend <= clr_pend_d;
      sda_oe   <= sda_oe_d;
      wr_valid <= wr_valid_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      soft_rst <= soft_rst_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    shreg_d    = shreg;
    tx_d       = tx;
    ptr_d      = ptr;
    clr_cnt_d  = clr_cnt;
    rnw_d      = rnw;
    clr_pend_d = clr_pend;
    sda_oe_d   = sda_oe;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    busy_d     = busy;
    soft_rst_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = shreg;

    // Line conditions outrank SCL edges; the sweep ignores the bus entirely.
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt + DATA_W'(1);
      if (clr_cnt == LAST_REG) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ptr_d   = '0;
      end
    end else if (start) begin
      state_d  = ST_DEV;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      sda_oe_d = 1'b0;
      if (clr_pend) begin
        state_d    = ST_CLEAR;
        busy_d     = 1'b1;
        clr_cnt_d  = '0;
        clr_pend_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state)
        ST_DEV, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shreg_d = {shreg[DATA_W-2:0], sda_s};
            cnt_d   = cnt + BIT_CNT_W'(1);
            if (state == ST_DEV && cnt == LAST_BIT) begin
              if (shreg[6:0] != DEV_ADDR || busy) state_d = ST_IDLE;
              else                                rnw_d   = sda_s;
            end
          end else if (scl_fall && cnt == BYTE_BITS) begin
            sda_oe_d = 1'b1;
            case (state)
              ST_DEV:  state_d = ST_DEV_ACK;
              ST_SUB: begin
                state_d = ST_SUB_ACK;
                ptr_d   = shreg;
              end
              default: state_d = ST_WDATA_ACK;
            endcase
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rnw) begin
              state_d  = ST_RDATA;
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[DATA_W-1];
            end else begin
              state_d  = ST_SUB;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_SUB_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WDATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr + DATA_W'(1);
            if (!is_id_reg(ptr)) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr;
              wr_data_d  = shreg;
              if (ptr == SOFT_RST_ADDR && shreg[DATA_W-1]) begin
                soft_rst_d = 1'b1;
                clr_pend_d = 1'b1;
              end
            end
          end else if (scl_fall) begin
            state_d  = ST_WDATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt == BYTE_BITS) begin
              state_d  = ST_RACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx[DATA_W-2];
              tx_d     = {tx[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            ptr_d = ptr + DATA_W'(1);
            if (sda_s) state_d = ST_IDLE;
          end else if (scl_fall) begin
            state_d  = ST_RDATA;
            cnt_d    = '0;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_reg_responder.sv
// Bench for sccb_reg_responder: bit-banged SCCB master with directed vectors.
module tb_sccb_reg_responder;
  import sccb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe, wr_valid, busy, soft_rst;
  logic [7:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] wv_q[$];
  int          soft_cnt = 0;
  int          busy_cnt = 0;
  logic        oe_seen  = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  sccb_reg_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .soft_rst (soft_rst)
  );

  always @(negedge clk) begin
    if (wr_valid) wv_q.push_back({wr_addr, wr_data});
    if (soft_rst) soft_cnt++;
    if (busy)     busy_cnt++;
    if (sda_oe)   oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sccb_start();
    sda_m = 1'b1; wclk(5);
    scl   = 1'b1; wclk(5);
    sda_m = 1'b0; wclk(5);
    scl   = 1'b0; wclk(5);
  endtask

  task automatic sccb_stop();
    sda_m = 1'b0; wclk(5);
    scl   = 1'b1; wclk(5);
    sda_m = 1'b1; wclk(10);
  endtask

  task automatic sccb_bit(input logic b, output logic r);
    sda_m = b;    wclk(5);
    scl   = 1'b1; wclk(5);
    r     = sda_line; wclk(5);
    scl   = 1'b0; wclk(5);
  endtask

  task automatic sccb_wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sccb_bit(d[i], r);
    sccb_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic sccb_rbyte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      sccb_bit(1'b1, r);
      d[i] = r;
    end
    sccb_bit(~mack, r);
  endtask

  task automatic sccb_write(input logic [7:0] sub, input int n, input logic [23:0] d, output int acks);
    logic a;
    acks = 0;
    sccb_start();
    sccb_wbyte(8'h42, a); acks += int'(a);
    sccb_wbyte(sub, a);   acks += int'(a);
    for (int i = n - 1; i >= 0; i--) begin
      sccb_wbyte(d[8*i +: 8], a);
      acks += int'(a);
    end
    sccb_stop();
  endtask

  task automatic sccb_read(input logic [7:0] sub, input int n, output int acks, output logic [23:0] data);
    logic       a;
    logic [7:0] b;
    acks = 0;
    data = '0;
    sccb_start();
    sccb_wbyte(8'h42, a); acks += int'(a);
    sccb_wbyte(sub, a);   acks += int'(a);
    sccb_stop();
    sccb_start();
    sccb_wbyte(8'h43, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      sccb_rbyte(i != n - 1, b);
      data = {data[15:0], b};
    end
    sccb_stop();
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (busy && k < 600) begin
      wclk(1);
      k++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    logic [7:0] sub;
    logic [7:0] wdata;
    logic       exp_wv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t        vt[7];
  int          acks, n0, s0;
  logic        a;
  logic [23:0] rd;

  initial begin
    vt[0] = '{8'h3D, 8'h03, 1'b1, 8'h03};
    vt[1] = '{8'h1C, 8'hFF, 1'b0, 8'h7F};
    vt[2] = '{8'h0A, 8'h00, 1'b0, 8'h77};
    vt[3] = '{8'h0B, 8'h55, 1'b0, 8'h21};
    vt[4] = '{8'h1D, 8'h11, 1'b0, 8'hA2};
    vt[5] = '{8'h40, 8'hA5, 1'b1, 8'hA5};
    vt[6] = '{8'h12, 8'h05, 1'b1, 8'h05};

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wclk(5);
    check("rst_sda_oe",   sda_oe,   0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_busy",     busy,     0);
    check("rst_soft_rst", soft_rst, 0);
    rst_n = 1'b1;
    wclk(5);

    // Clear the array before relying on its contents.
    busy_cnt = 0;
    sccb_write(8'h12, 1, 24'h80, acks);
    check("init_clr_acks", acks, 3);
    wait_not_busy("init_clr_done");
    check("init_clr_busy_cycles", busy_cnt, 256);
    check("init_soft_cnt", soft_cnt, 1);

    for (int i = 0; i < 7; i++) begin
      n0 = wv_q.size();
      s0 = soft_cnt;
      sccb_write(vt[i].sub, 1, {16'h0, vt[i].wdata}, acks);
      check($sformatf("v%0d_wr_acks", i), acks, 3);
      check($sformatf("v%0d_wv_count", i), wv_q.size() - n0, int'(vt[i].exp_wv));
      if (vt[i].exp_wv) check($sformatf("v%0d_wv_payload", i), wv_q[$], {vt[i].sub, vt[i].wdata});
      check($sformatf("v%0d_no_soft_rst", i), soft_cnt - s0, 0);
      sccb_read(vt[i].sub, 1, acks, rd);
      check($sformatf("v%0d_rd_acks", i), acks, 3);
      check($sformatf("v%0d_rd_data", i), rd[7:0], vt[i].exp_rd);
    end

    // ID burst read with master ACK then NACK.
    sccb_read(8'h1C, 2, acks, rd);
    check("id_burst_acks", acks, 3);
    check("id_burst_data", rd[15:0], 16'h7FA2);

    // Foreign device address is NACKed and ignored.
    n0 = wv_q.size();
    oe_seen = 1'b0;
    sccb_start();
    sccb_wbyte(8'h60, a);
    check("foreign_nack", a, 0);
    check("foreign_oe_quiet", oe_seen, 0);
    sccb_wbyte(8'h00, a);
    check("foreign_idle", a, 0);
    sccb_stop();
    check("foreign_no_wv", wv_q.size() - n0, 0);

    // Burst write across the pointer wrap.
    n0 = wv_q.size();
    sccb_write(8'hFE, 3, 24'h112233, acks);
    check("wrap_acks", acks, 5);
    check("wrap_wv_count", wv_q.size() - n0, 3);
    if (wv_q.size() - n0 == 3) begin
      check("wrap_wv0", wv_q[n0],     16'hFE11);
      check("wrap_wv1", wv_q[n0 + 1], 16'hFF22);
      check("wrap_wv2", wv_q[n0 + 2], 16'h0033);
    end
    sccb_read(8'hFE, 3, acks, rd);
    check("wrap_rd_acks", acks, 3);
    check("wrap_rd_data", rd, 24'h112233);

    // Soft reset: pulse, 256-cycle sweep, NACK while busy, array cleared.
    n0 = wv_q.size();
    s0 = soft_cnt;
    busy_cnt = 0;
    sccb_write(8'h12, 1, 24'h80, acks);
    check("srst_acks", acks, 3);
    check("srst_pulse", soft_cnt - s0, 1);
    check("srst_wv", wv_q[$], 16'h1280);
    check("srst_busy_now", busy, 1);
    sccb_start();
    sccb_wbyte(8'h42, a);
    check("srst_busy_nack", a, 0);
    sccb_stop();
    wait_not_busy("srst_done");
    check("srst_busy_cycles", busy_cnt, 256);
    sccb_read(8'h3D, 1, acks, rd);
    check("srst_rd_acks", acks, 3);
    check("srst_cleared", rd[7:0], 8'h00);

    // Reset asserted while the responder drives SDA mid-read.
    sccb_write(8'h1C, 0, 24'h0, acks);
    check("mid_ptr_acks", acks, 2);
    sccb_start();
    sccb_wbyte(8'h43, a);
    check("mid_dev_ack", a, 1);
    wclk(1);
    check("mid_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", sda_oe, 0);
    wclk(3);
    check("mid_rst_wv", wr_valid, 0);
    rst_n = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    wclk(10);
    n0 = wv_q.size();
    sccb_write(8'h50, 1, 24'h5A, acks);
    check("post_rst_acks", acks, 3);
    check("post_rst_wv", (wv_q.size() > n0) ? wv_q[$] : 16'h0, 16'h505A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
